serial_adder_ctrl: RTL and testbench

//   Bit-serial adder controller: accepts two WIDTH-bit operands and a carry-in over
//   a valid/ready handshake, then feeds them LSB-first through one 1-bit full adder
//   (two half_adder instances plus an OR for carry), one bit per clock.
//   The block assembles the sum in a shift register and returns sum/cout over a

---
 rtl/serial_adder_ctrl_if.sv | 45 ++++
 rtl/serial_adder_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
//   Bundles the operand and result handshakes of the bit-serial adder.
//
//   Handshake rule: a transfer happens on a rising clk edge where valid and
//   ready are both high. Once valid is raised, the payload stays stable until
//   that edge. ready may be high before valid.
//
//   Signals:
//     in_valid / in_ready   operand handshake (a, b, cin)
//     a, b                  WIDTH-bit operands
//     cin                   carry-in for bit 0
//     out_valid / out_ready result handshake (sum, cout)
//     sum                   (a + b + cin) mod 2^WIDTH
//     cout                  carry out of bit WIDTH-1
//     busy                  controller is running or holding a result
//
//   Modports:
//     master  producer of operands and consumer of results
//     slave   the adder controller
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder. It captures two WIDTH-bit operands and a carry-in, then
//   pushes them LSB-first through one full adder, one bit per clock. The full
//   adder is built from two half adders plus an OR for the carry. Sum bits
//   enter the MSB of a right-shifting register, so after WIDTH edges the
//   register holds the complete sum.
//
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     sa_if     operand/result handshakes (serial_adder_ctrl_if.slave)
//     state_o   current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//
//   Timing: the result is valid WIDTH edges after the accepting edge. It is
//   held until consumed. The controller is back in IDLE on the edge after
//   consumption, so transactions never overlap.
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  sa_if,
   output logic [1:0]          state_o
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             carry_q;
   logic             carry_d;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic [CW-1:0]    cnt_q;
   logic [1:0]       ha0;
   logic [1:0]       ha1;

   // Half adder: returns {carry, sum}.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   // One full-adder step on the current LSBs and the running carry.
   always_comb begin
      ha0     = half_add(a_sh_q[0], b_sh_q[0]);
      ha1     = half_add(ha0[0], carry_q);
      carry_d = ha0[1] | ha1[1];
      sum_d   = sum_q >> 1;
      sum_d[WIDTH-1] = ha1[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         carry_q     <= 1'b0;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         sum_q       <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sa_if.in_valid) begin
                  a_sh_q     <= sa_if.a;
                  b_sh_q     <= sa_if.b;
                  carry_q    <= sa_if.cin;
                  cnt_q      <= '0;
                  state_q    <= ST_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_RUN: begin
               sum_q   <= sum_d;
               carry_q <= carry_d;
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               cnt_q   <= cnt_q + CW'(1);
               // This edge consumes bit WIDTH-1, so the sum is complete after it.
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_q     <= ST_DONE;
                  out_valid_q <= 1'b1;
               end
            end
            ST_DONE: begin
               if (sa_if.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign sa_if.in_ready  = in_ready_q;
   assign sa_if.out_valid = out_valid_q;
   assign sa_if.busy      = busy_q;
   assign sa_if.sum       = sum_q;
   assign sa_if.cout      = carry_q;
   assign state_o         = state_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Bench for serial_adder_ctrl at WIDTH=4, WIDTH=1 and WIDTH=8. Drivers push
//   the expected {cout, sum} into a per-instance queue when they issue an
//   operation. Monitors pop and compare whenever a result handshake fires.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;
   logic clk;
   logic rst_n;
   logic [1:0] st4, st1, st8;

   int checks = 0;
   int errors = 0;

   logic [4:0] exp4_q[$];
   logic [1:0] exp1_q[$];
   logic [8:0] exp8_q[$];

   serial_adder_ctrl_if #(.WIDTH(4)) if4 ();
   serial_adder_ctrl_if #(.WIDTH(1)) if1 ();
   serial_adder_ctrl_if #(.WIDTH(8)) if8 ();

   serial_adder_ctrl #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .sa_if(if4), .state_o(st4));
   serial_adder_ctrl #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .sa_if(if1), .state_o(st1));
   serial_adder_ctrl #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .sa_if(if8), .state_o(st8));

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitors / scoreboards ----------------
   always @(negedge clk) begin : mon4
      logic [4:0] e;
      if (rst_n && if4.out_valid && if4.out_ready) begin
         if (exp4_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w4_unexpected_result: got 0x%0h expected none", {if4.cout, if4.sum});
         end else begin
            e = exp4_q.pop_front();
            chk("w4_result", 32'({if4.cout, if4.sum}), 32'(e));
         end
      end
   end

   always @(negedge clk) begin : mon1
      logic [1:0] e;
      if (rst_n && if1.out_valid && if1.out_ready) begin
         if (exp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w1_unexpected_result: got 0x%0h expected none", {if1.cout, if1.sum});
         end else begin
            e = exp1_q.pop_front();
            chk("w1_result", 32'({if1.cout, if1.sum}), 32'(e));
         end
      end
   end

   always @(negedge clk) begin : mon8
      logic [8:0] e;
      if (rst_n && if8.out_valid && if8.out_ready) begin
         if (exp8_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL w8_unexpected_result: got 0x%0h expected none", {if8.cout, if8.sum});
         end else begin
            e = exp8_q.pop_front();
            chk("w8_result", 32'({if8.cout, if8.sum}), 32'(e));
         end
      end
   end

   // ---------------- drivers (called at posedge + #1) ----------------
   task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [4:0] exp);
      int n = 0;
      while (!if4.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("w4_in_ready_wait", 32'(if4.in_ready), 32'd1);
      if4.a = a; if4.b = b; if4.cin = c; if4.in_valid = 1'b1;
      exp4_q.push_back(exp);
      @(posedge clk); #1;
      if4.in_valid = 1'b0;
   endtask

   task automatic send1(input logic a, input logic b, input logic c, input logic [1:0] exp);
      int n = 0;
      while (!if1.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("w1_in_ready_wait", 32'(if1.in_ready), 32'd1);
      if1.a = a; if1.b = b; if1.cin = c; if1.in_valid = 1'b1;
      exp1_q.push_back(exp);
      @(posedge clk); #1;
      if1.in_valid = 1'b0;
   endtask

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp);
      int n = 0;
      while (!if8.in_ready && n < 100) begin @(posedge clk); #1; n++; end
      chk("w8_in_ready_wait", 32'(if8.in_ready), 32'd1);
      if8.a = a; if8.b = b; if8.cin = c; if8.in_valid = 1'b1;
      exp8_q.push_back(exp);
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp4_q.size() + exp1_q.size() + exp8_q.size()) != 0 && n < 400) begin
         @(posedge clk); #1; n++;
      end
      chk("drain_pending", 32'(exp4_q.size() + exp1_q.size() + exp8_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [8:0] t4_ops [2];
   logic [4:0] t4_exp [2];
   logic [1:0] w1_tab [8];

   initial begin
      int n;
      int idx;
      int acc;
      int hits;
      logic [7:0] ra, rb;
      logic       rc;
      logic [2:0] v;

      t4_ops = '{{4'h5, 4'h6, 1'b0}, {4'h9, 4'h9, 1'b1}};
      t4_exp = '{5'h0B, 5'h13};
      w1_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

      if4.in_valid = 0; if4.a = 0; if4.b = 0; if4.cin = 0; if4.out_ready = 1;
      if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.cin = 0; if1.out_ready = 1;
      if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.cin = 0; if8.out_ready = 1;

      // Asynchronous reset, checked before any clock edge.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", 32'(if4.in_ready), 32'd1);
      chk("rst_out_valid", 32'(if4.out_valid), 32'd0);
      chk("rst_busy", 32'(if4.busy), 32'd0);
      chk("rst_sum_cout", 32'({if4.cout, if4.sum}), 32'd0);
      chk("rst_state", 32'(st4), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Zero operands and latency of WIDTH edges.
      send4(4'h0, 4'h0, 1'b0, 5'h00);
      chk("w4_run_busy", 32'(if4.busy), 32'd1);
      chk("w4_run_in_ready", 32'(if4.in_ready), 32'd0);
      chk("w4_run_state", 32'(st4), 32'd1);
      n = 0;
      while (!if4.out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("w4_latency", 32'(n), 32'd4);

      // Full carry ripple.
      send4(4'hF, 4'h1, 1'b0, 5'h10);
      send4(4'hA, 4'h5, 1'b1, 5'h10);
      drain();

      // Backpressure: result held stable while out_ready is low.
      if4.out_ready = 1'b0;
      send4(4'h3, 4'h4, 1'b0, 5'h07);
      n = 0;
      while (!if4.out_valid && n < 50) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(if4.out_valid), 32'd1);
         chk("bp_sum_cout", 32'({if4.cout, if4.sum}), 32'h07);
         chk("bp_in_ready", 32'(if4.in_ready), 32'd0);
      end
      @(posedge clk); #1;
      if4.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_state", 32'(st4), 32'd0);
      chk("bp_release_in_ready", 32'(if4.in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(if4.out_valid), 32'd0);
      chk("bp_sum_retained", 32'(if4.sum), 32'h7);

      // in_valid held high, operands scrambled while busy; back-to-back ops.
      idx = 0;
      acc = -1;
      {if4.a, if4.b, if4.cin} = t4_ops[0];
      if4.in_valid = 1'b1;
      exp4_q.push_back(t4_exp[0]);
      for (int cyc = 1; cyc <= 60 && idx < 2; cyc++) begin
         @(posedge clk); #1;
         if (!if4.in_ready) begin
            if (acc < 0) acc = cyc;
            if4.a   = 4'($urandom_range(0, 15));
            if4.b   = 4'($urandom_range(0, 15));
            if4.cin = 1'($urandom_range(0, 1));
         end else if (acc >= 0) begin
            chk("w4_occupancy", 32'(cyc - acc), 32'd5);
            idx++;
            acc = -1;
            if (idx < 2) begin
               {if4.a, if4.b, if4.cin} = t4_ops[idx];
               exp4_q.push_back(t4_exp[idx]);
            end else begin
               if4.in_valid = 1'b0;
            end
         end
      end
      chk("w4_b2b_ops_done", 32'(idx), 32'd2);
      if4.in_valid = 1'b0;
      drain();

      // Reset in the middle of RUN aborts the operation.
      send4(4'hF, 4'h0, 1'b0, 5'h0F);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp4_q.delete();
      #1;
      chk("abort_state", 32'(st4), 32'd0);
      chk("abort_in_ready", 32'(if4.in_ready), 32'd1);
      chk("abort_busy", 32'(if4.busy), 32'd0);
      chk("abort_sum", 32'(if4.sum), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("abort_release_in_ready", 32'(if4.in_ready), 32'd1);
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (if4.out_valid) hits++;
      end
      chk("abort_no_out_valid", 32'(hits), 32'd0);
      @(posedge clk); #1;
      send4(4'h6, 4'h3, 1'b0, 5'h09);
      drain();

      // WIDTH=1: one edge of RUN, exhaustive full-adder table.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         send1(v[2], v[1], v[0], w1_tab[i]);
         if (i == 0) begin
            n = 0;
            while (!if1.out_valid && n < 50) begin @(posedge clk); #1; n++; end
            chk("w1_latency", 32'(n), 32'd1);
         end
      end
      drain();

      // WIDTH=8: directed corners, then random regression against a+b+cin.
      send8(8'hFF, 8'h00, 1'b1, 9'h100);
      send8(8'h80, 8'h80, 1'b0, 9'h100);
      send8(8'h7F, 8'h01, 1'b0, 9'h080);
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         send8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
